bank_burst_arbiter: RTL and testbench

//  Parametrised successor to the 16-bank back-end arbiter. Selects one bank

---
 rtl/bank_burst_arbiter.sv | 172 +++++++++++++++++
 tb/tb_bank_burst_arbiter.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bank_burst_arbiter.sv
// Bank burst arbiter: round-robin selection over NUM_BANKS bank schedulers,
// holding the grant on one bank for up to MAX_BURST beats within the current
// read/write phase, and registering the granted command for the next stage.
// Optional feature: define ARB_ROW_HIT_EN to require a row hit for burst
// continuation (a row change releases the bank).
module bank_burst_arbiter #(
  parameter int unsigned NUM_BANKS  = 16,
  parameter int unsigned BA_BITS    = 2,
  parameter int unsigned BG_BITS    = 2,
  parameter int unsigned INDEX_BITS = 7,
  parameter int unsigned RA_BITS    = 16,
  parameter int unsigned CA_BITS    = 10,
  parameter int unsigned DATA_BITS  = 16,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_BANKS-1:0]            valid,
  input  logic                            flag,
  input  logic                            stall_i,
  input  logic [NUM_BANKS*DATA_BITS-1:0]  data_i,
  input  logic [NUM_BANKS*INDEX_BITS-1:0] idx_i,
  input  logic [NUM_BANKS*RA_BITS-1:0]    row_i,
  input  logic [NUM_BANKS*CA_BITS-1:0]    col_i,
  input  logic [NUM_BANKS-1:0]            t_i,
  output logic [NUM_BANKS-1:0]            Ready,
  output logic                            wr_en,
  output logic [DATA_BITS-1:0]            data_o,
  output logic [INDEX_BITS-1:0]           idx_o,
  output logic [RA_BITS-1:0]              row_o,
  output logic [CA_BITS-1:0]              col_o,
  output logic                            t_o,
  output logic [BA_BITS-1:0]              ba_o,
  output logic [BG_BITS-1:0]              bg_o
);

  localparam int unsigned BANK_W = BA_BITS + BG_BITS;
  localparam int unsigned CNT_W  = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                state_q, state_d;
  logic [BANK_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [BANK_W-1:0]     owner_q, owner_d;
  logic [CNT_W-1:0]      burst_cnt_q, burst_cnt_d;
  logic [NUM_BANKS-1:0]  eligible;
  logic                  row_ok;
  logic                  gnt_vld_c;
  logic [BANK_W-1:0]     gnt_idx_c;
  logic [BANK_W:0]       pick_res;

  logic [DATA_BITS-1:0]  data_a [NUM_BANKS];
  logic [INDEX_BITS-1:0] idx_a  [NUM_BANKS];
  logic [RA_BITS-1:0]    row_a  [NUM_BANKS];
  logic [CA_BITS-1:0]    col_a  [NUM_BANKS];

  // Split the flat per-bank buses into per-bank fields
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_unpack
    assign data_a[b] = data_i[b*DATA_BITS +: DATA_BITS];
    assign idx_a[b]  = idx_i[b*INDEX_BITS +: INDEX_BITS];
    assign row_a[b]  = row_i[b*RA_BITS +: RA_BITS];
    assign col_a[b]  = col_i[b*CA_BITS +: CA_BITS];
  end

  assign eligible = valid & ~(t_i ^ {NUM_BANKS{flag}});

`ifdef ARB_ROW_HIT_EN
  // row_o always holds the last granted row
  assign row_ok = (row_a[owner_q] == row_o);
`else
  assign row_ok = 1'b1;
`endif

  // First requesting bank at or after start, wrapping; MSB flags a hit
  function automatic logic [BANK_W:0] pick(input logic [NUM_BANKS-1:0] req,
                                           input logic [BANK_W-1:0]    start);
    logic [BANK_W-1:0] idx;
    pick = '0;
    for (int k = NUM_BANKS - 1; k >= 0; k--) begin
      idx = start + BANK_W'(k);
      if (req[idx]) pick = {1'b1, idx};
    end
  endfunction

  // FSM state, round-robin pointer, burst owner and beat counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // Next-state and grant selection; release searches from owner+1 so the
  // owner itself is only regranted when nobody else is eligible
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    gnt_vld_c   = 1'b0;
    gnt_idx_c   = owner_q;
    pick_res    = '0;
    if (rst_n && !stall_i) begin
      case (state_q)
        IDLE: begin
          pick_res = pick(eligible, rr_ptr_q);
          if (pick_res[BANK_W]) begin
            gnt_vld_c   = 1'b1;
            gnt_idx_c   = pick_res[BANK_W-1:0];
            state_d     = BURST;
            owner_d     = pick_res[BANK_W-1:0];
            burst_cnt_d = CNT_W'(1);
          end
        end
        BURST: begin
          if (eligible[owner_q] && (burst_cnt_q < CNT_W'(MAX_BURST)) && row_ok) begin
            gnt_vld_c   = 1'b1;
            gnt_idx_c   = owner_q;
            burst_cnt_d = burst_cnt_q + CNT_W'(1);
          end else begin
            rr_ptr_d = owner_q + BANK_W'(1);
            pick_res = pick(eligible, owner_q + BANK_W'(1));
            if (pick_res[BANK_W]) begin
              gnt_vld_c   = 1'b1;
              gnt_idx_c   = pick_res[BANK_W-1:0];
              owner_d     = pick_res[BANK_W-1:0];
              burst_cnt_d = CNT_W'(1);
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign Ready = gnt_vld_c ? (NUM_BANKS'(1) << gnt_idx_c) : '0;

  // Registered command toward the timing/PHY stage; fields hold when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en  <= 1'b0;
      data_o <= '0;
      idx_o  <= '0;
      row_o  <= '0;
      col_o  <= '0;
      t_o    <= 1'b0;
      ba_o   <= '0;
      bg_o   <= '0;
    end else begin
      wr_en <= gnt_vld_c;
      if (gnt_vld_c) begin
        data_o <= data_a[gnt_idx_c];
        idx_o  <= idx_a[gnt_idx_c];
        row_o  <= row_a[gnt_idx_c];
        col_o  <= col_a[gnt_idx_c];
        t_o    <= t_i[gnt_idx_c];
        ba_o   <= gnt_idx_c[BA_BITS-1:0];
        bg_o   <= gnt_idx_c[BANK_W-1:BA_BITS];
      end
    end
  end

endmodule

// File: tb/tb_bank_burst_arbiter.sv
// Self-checking bench for bank_burst_arbiter: directed scenarios plus a
// randomized run against a behavioural arbitration model.
module tb_bank_burst_arbiter;

  localparam int unsigned N  = 16;
  localparam int unsigned IW = 7;
  localparam int unsigned RW = 16;
  localparam int unsigned CW = 10;
  localparam int unsigned DW = 16;
  localparam int          MB = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  valid;
  logic          flag;
  logic          stall_i;
  logic [N*DW-1:0] data_i;
  logic [N*IW-1:0] idx_i;
  logic [N*RW-1:0] row_i;
  logic [N*CW-1:0] col_i;
  logic [N-1:0]  t_i;
  logic [N-1:0]  Ready;
  logic          wr_en;
  logic [DW-1:0] data_o;
  logic [IW-1:0] idx_o;
  logic [RW-1:0] row_o;
  logic [CW-1:0] col_o;
  logic          t_o;
  logic [1:0]    ba_o;
  logic [1:0]    bg_o;

  logic [DW-1:0] bd [N];
  logic [IW-1:0] bi [N];
  logic [RW-1:0] br [N];
  logic [CW-1:0] bc [N];

  int checks = 0;
  int failures = 0;

  // model state
  int m_ptr, m_owner, m_beats, m_gnt;
  bit m_burst;
  int n_ptr, n_owner, n_beats;
  bit n_burst;
  logic [DW-1:0] g_data;
  logic [IW-1:0] g_idx;
  logic [RW-1:0] g_row;
  logic [CW-1:0] g_col;
  logic          g_t;
  logic          e_wr;
  logic [DW-1:0] e_data;
  logic [IW-1:0] e_idx;
  logic [RW-1:0] e_row;
  logic [CW-1:0] e_col;
  logic          e_t;
  logic [3:0]    e_bank;

  bank_burst_arbiter dut (
    .clk(clk), .rst_n(rst_n), .valid(valid), .flag(flag), .stall_i(stall_i),
    .data_i(data_i), .idx_i(idx_i), .row_i(row_i), .col_i(col_i), .t_i(t_i),
    .Ready(Ready), .wr_en(wr_en), .data_o(data_o), .idx_o(idx_o),
    .row_o(row_o), .col_o(col_o), .t_o(t_o), .ba_o(ba_o), .bg_o(bg_o)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int b = 0; b < N; b++) begin
      data_i[b*DW +: DW] = bd[b];
      idx_i[b*IW +: IW]  = bi[b];
      row_i[b*RW +: RW]  = br[b];
      col_i[b*CW +: CW]  = bc[b];
    end
  end

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    valid   = '0;
    stall_i = 1'b0;
    repeat (2) edge1();
    rst_n = 1'b1;
  endtask

  function automatic bit elig(int i);
    return valid[i] && (t_i[i] == flag);
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_owner = 0; m_beats = 0; m_burst = 0;
    e_wr = 0; e_data = '0; e_idx = '0; e_row = '0; e_col = '0; e_t = 0; e_bank = '0;
  endtask

  // Decide this cycle's grant from the arbitration rules
  task automatic model_eval();
    bit row_hit;
    int start;
    n_ptr = m_ptr; n_owner = m_owner; n_beats = m_beats; n_burst = m_burst;
    m_gnt = -1;
    if (!stall_i) begin
      row_hit = 1;
`ifdef ARB_ROW_HIT_EN
      row_hit = (br[m_owner] == e_row);
`endif
      if (m_burst && elig(m_owner) && m_beats < MB && row_hit) begin
        m_gnt = m_owner;
        n_beats = m_beats + 1;
      end else begin
        start = m_burst ? (m_owner + 1) % N : m_ptr;
        if (m_burst) n_ptr = start;
        for (int k = 0; k < N; k++)
          if (m_gnt < 0 && elig((start + k) % N)) m_gnt = (start + k) % N;
        if (m_gnt >= 0) begin
          n_owner = m_gnt; n_beats = 1; n_burst = 1;
        end else begin
          n_burst = 0;
        end
      end
      if (m_gnt >= 0) begin
        g_data = bd[m_gnt]; g_idx = bi[m_gnt]; g_row = br[m_gnt];
        g_col = bc[m_gnt]; g_t = t_i[m_gnt];
      end
    end
  endtask

  task automatic model_commit();
    m_ptr = n_ptr; m_owner = n_owner; m_beats = n_beats; m_burst = n_burst;
    e_wr = (m_gnt >= 0);
    if (m_gnt >= 0) begin
      e_data = g_data; e_idx = g_idx; e_row = g_row; e_col = g_col; e_t = g_t;
      e_bank = 4'(m_gnt);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; valid = 16'hFFFF; t_i = 16'hFFFF; flag = 1'b1; stall_i = 1'b0;
    repeat (2) edge1();
    checks++;
    if (Ready !== 16'h0 || wr_en !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready: Ready=%h wr_en=%b expected 0000/0", Ready, wr_en);
    end
    checks++;
    if ({data_o, idx_o, row_o, col_o, t_o, ba_o, bg_o} !== '0) begin
      failures++;
      $display("FAIL reset_fields: data=%h row=%h col=%h expected all zero", data_o, row_o, col_o);
    end
    rst_n = 1'b1;
    #2;
    checks++;
    if (Ready !== 16'h0001) begin
      failures++;
      $display("FAIL reset_first_grant: Ready=%h expected 0001", Ready);
    end
    edge1();
    checks++;
    if (wr_en !== 1'b1 || data_o !== bd[0] || row_o !== br[0] || ba_o !== 2'd0 || bg_o !== 2'd0) begin
      failures++;
      $display("FAIL reset_first_cmd: wr_en=%b data=%h row=%h expected 1 %h %h", wr_en, data_o, row_o, bd[0], br[0]);
    end
  endtask

  task automatic test_burst_cap();
    logic [15:0] exp;
    do_reset();
    flag = 1'b1; valid = 16'h0005; t_i = 16'hFFFF;
    for (int c = 0; c < 16; c++) begin
      exp = (((c / 4) % 2) == 0) ? 16'h0001 : 16'h0004;
      #2;
      checks++;
      if (Ready !== exp) begin
        failures++;
        $display("FAIL burst_cap_ready[%0d]: Ready=%h expected %h", c, Ready, exp);
      end
      edge1();
      checks++;
      if (wr_en !== 1'b1 || ba_o !== ((exp == 16'h0001) ? 2'd0 : 2'd2)) begin
        failures++;
        $display("FAIL burst_cap_cmd[%0d]: wr_en=%b ba=%0d", c, wr_en, ba_o);
      end
    end
  endtask

  task automatic test_phase();
    do_reset();
    flag = 1'b0; valid = 16'h0003; t_i = 16'h0001;
    for (int c = 0; c < 3; c++) begin
      #2;
      checks++;
      if (Ready !== 16'h0002) begin
        failures++;
        $display("FAIL phase_read[%0d]: Ready=%h expected 0002", c, Ready);
      end
      edge1();
      checks++;
      if (wr_en !== 1'b1 || t_o !== 1'b0 || ba_o !== 2'd1) begin
        failures++;
        $display("FAIL phase_read_cmd[%0d]: wr_en=%b t=%b ba=%0d expected 1 0 1", c, wr_en, t_o, ba_o);
      end
    end
    flag = 1'b1;
    #2;
    checks++;
    if (Ready !== 16'h0001) begin
      failures++;
      $display("FAIL phase_flip: Ready=%h expected 0001", Ready);
    end
    edge1();
    checks++;
    if (wr_en !== 1'b1 || t_o !== 1'b1 || ba_o !== 2'd0) begin
      failures++;
      $display("FAIL phase_flip_cmd: wr_en=%b t=%b ba=%0d expected 1 1 0", wr_en, t_o, ba_o);
    end
  endtask

  task automatic test_stall();
    logic [15:0] exp;
    do_reset();
    flag = 1'b1; t_i = 16'hFFFF; valid = 16'h0060;
    for (int c = 0; c < 8; c++) begin
      stall_i = (c >= 2 && c < 5);
      exp = stall_i ? 16'h0000 : ((c < 7) ? 16'h0020 : 16'h0040);
      #2;
      checks++;
      if (Ready !== exp) begin
        failures++;
        $display("FAIL stall_ready[%0d]: Ready=%h expected %h", c, Ready, exp);
      end
      edge1();
      checks++;
      if (stall_i) begin
        if (wr_en !== 1'b0 || data_o !== bd[5]) begin
          failures++;
          $display("FAIL stall_hold[%0d]: wr_en=%b data=%h expected 0 %h", c, wr_en, data_o, bd[5]);
        end
      end else if (c < 7) begin
        if (wr_en !== 1'b1 || ba_o !== 2'd1 || bg_o !== 2'd1) begin
          failures++;
          $display("FAIL stall_cmd[%0d]: wr_en=%b ba=%0d bg=%0d expected 1 1 1", c, wr_en, ba_o, bg_o);
        end
      end else if (wr_en !== 1'b1 || ba_o !== 2'd2 || bg_o !== 2'd1) begin
        failures++;
        $display("FAIL stall_next_cmd: wr_en=%b ba=%0d bg=%0d expected 1 2 1", wr_en, ba_o, bg_o);
      end
    end
    stall_i = 1'b0;
  endtask

  task automatic test_row_hit();
    logic [15:0] exp_g [3];
    logic [15:0] exp_r [3];
    do_reset();
    flag = 1'b1; t_i = 16'hFFFF; valid = 16'h000C;
    br[2] = 16'h0010; br[3] = 16'h0033;
    exp_g[0] = 16'h0004; exp_g[1] = 16'h0004;
    exp_r[0] = 16'h0010; exp_r[1] = 16'h0010;
`ifdef ARB_ROW_HIT_EN
    exp_g[2] = 16'h0008; exp_r[2] = 16'h0033;
`else
    exp_g[2] = 16'h0004; exp_r[2] = 16'h0020;
`endif
    for (int c = 0; c < 3; c++) begin
      #2;
      checks++;
      if (Ready !== exp_g[c]) begin
        failures++;
        $display("FAIL row_hit_ready[%0d]: Ready=%h expected %h", c, Ready, exp_g[c]);
      end
      edge1();
      checks++;
      if (wr_en !== 1'b1 || row_o !== exp_r[c]) begin
        failures++;
        $display("FAIL row_hit_row[%0d]: wr_en=%b row=%h expected 1 %h", c, wr_en, row_o, exp_r[c]);
      end
      if (c == 1) br[2] = 16'h0020;
    end
  endtask

  task automatic test_wrap();
    logic [15:0] exp;
    do_reset();
    flag = 1'b1; t_i = 16'hFFFF; valid = 16'h8000;
    for (int c = 0; c < 9; c++) begin
      if (c == 4) valid = 16'h8001;
      exp = (c >= 4 && c < 8) ? 16'h0001 : 16'h8000;
      #2;
      checks++;
      if (Ready !== exp) begin
        failures++;
        $display("FAIL wrap_ready[%0d]: Ready=%h expected %h", c, Ready, exp);
      end
      edge1();
    end
    checks++;
    if (ba_o !== 2'd3 || bg_o !== 2'd3 || wr_en !== 1'b1) begin
      failures++;
      $display("FAIL wrap_cmd: ba=%0d bg=%0d wr_en=%b expected 3 3 1", ba_o, bg_o, wr_en);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    flag = 1'b1; t_i = 16'hFFFF; valid = 16'h0009;
    repeat (4) edge1();
    #2;
    checks++;
    if (Ready !== 16'h0008) begin
      failures++;
      $display("FAIL reset_mid_pre: Ready=%h expected 0008", Ready);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (Ready !== 16'h0000 || wr_en !== 1'b0 || row_o !== '0) begin
      failures++;
      $display("FAIL reset_mid_clear: Ready=%h wr_en=%b row=%h expected 0", Ready, wr_en, row_o);
    end
    edge1();
    rst_n = 1'b1;
    #2;
    checks++;
    if (Ready !== 16'h0001) begin
      failures++;
      $display("FAIL reset_mid_restart: Ready=%h expected 0001", Ready);
    end
    edge1();
  endtask

  task automatic test_random();
    logic [15:0] exp_ready;
    logic [54:0] got, exp;
    do_reset();
    model_reset();
    flag = 1'(($urandom() & 1));
    t_i = 16'($urandom());
    for (int c = 0; c < 600; c++) begin
      case ($urandom_range(0, 5))
        0: valid = 16'($urandom());
        1: valid = 16'(1) << $urandom_range(0, 15);
        2: valid = 16'($urandom()) & 16'($urandom());
        default: ;
      endcase
      if ($urandom_range(0, 3) == 0) t_i = 16'($urandom());
      if ($urandom_range(0, 9) == 0) flag = ~flag;
      stall_i = ($urandom_range(0, 4) == 0);
      for (int b = 0; b < N; b++) begin
        bd[b] = 16'($urandom());
        bi[b] = 7'($urandom());
        bc[b] = 10'($urandom());
        if ($urandom_range(0, 3) == 0) br[b] = 16'($urandom_range(0, 1));
      end
      #2;
      model_eval();
      exp_ready = (m_gnt >= 0) ? (16'(1) << m_gnt) : 16'h0;
      checks++;
      if (Ready !== exp_ready) begin
        failures++;
        $display("FAIL rand_ready[%0d]: Ready=%h expected %h", c, Ready, exp_ready);
      end
      edge1();
      model_commit();
      got = {wr_en, data_o, idx_o, row_o, col_o, t_o, ba_o, bg_o};
      exp = {e_wr, e_data, e_idx, e_row, e_col, e_t, e_bank[1:0], e_bank[3:2]};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL rand_cmd[%0d]: got %h expected %h", c, got, exp);
      end
    end
    stall_i = 1'b0;
  endtask

  initial begin
    for (int b = 0; b < N; b++) begin
      bd[b] = 16'hA000 | 16'(b);
      bi[b] = 7'(b + 1);
      br[b] = 16'h0100 + 16'(b);
      bc[b] = 10'(b * 3);
    end
    test_reset();
    test_burst_cap();
    test_phase();
    test_stall();
    test_row_hit();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
